eth_phy_10g: RTL and testbench

ETH_PHY_10G -- requirements
Module: eth_phy_10g

---
 rtl/eth_phy_10g.sv | 343 ++++++++++++++++++++++++++++++++++
 tb/tb_eth_phy_10g.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_phy_10g.sv
// eth_phy_10g: 10GBASE-R PCS datapath between a 64-bit XGMII and a 64b/66b SerDes.
// The TX side encodes XGMII words into 66-bit blocks and scrambles them, or emits
// PRBS31 when the TX test mode is on. The RX side does block lock (bitslip
// requests), BER monitoring, descrambling, decoding, frame-sequence checking and
// PRBS31 error counting.
// Ports:
//   clk, rst                             clock, asynchronous active-high reset
//   xgmii_txd/txc   -> serdes_tx_data/hdr    TX path, one cycle of latency
//   serdes_rx_data/hdr -> xgmii_rxd/rxc      RX path, one cycle of latency
//   serdes_rx_bitslip, serdes_rx_reset_req   single-cycle requests to the SerDes
//   tx_bad_block, rx_bad_block, rx_sequence_error, rx_error_count   per-block flags
//   rx_block_lock, rx_high_ber, rx_status    link status
//   cfg_tx_prbs31_enable, cfg_rx_prbs31_enable   PRBS31 test modes
module eth_phy_10g #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] xgmii_txd,
    input  logic [CTRL_WIDTH-1:0] xgmii_txc,
    output logic [DATA_WIDTH-1:0] xgmii_rxd,
    output logic [CTRL_WIDTH-1:0] xgmii_rxc,
    output logic [DATA_WIDTH-1:0] serdes_tx_data,
    output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
    input  logic [DATA_WIDTH-1:0] serdes_rx_data,
    input  logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
    output logic                  serdes_rx_bitslip,
    output logic                  serdes_rx_reset_req,
    output logic                  tx_bad_block,
    output logic                  rx_bad_block,
    output logic                  rx_sequence_error,
    output logic [6:0]            rx_error_count,
    output logic                  rx_block_lock,
    output logic                  rx_high_ber,
    output logic                  rx_status,
    input  logic                  cfg_tx_prbs31_enable,
    input  logic                  cfg_rx_prbs31_enable
);
    localparam logic [1:0]  SYNC_DATA = 2'b01;
    localparam logic [1:0]  SYNC_CTRL = 2'b10;
    localparam logic [63:0] IDLE_WORD = 64'h0707070707070707;
    localparam logic [63:0] ERR_WORD  = 64'hFEFEFEFEFEFEFEFE;

    typedef enum logic [2:0] {BLK_DATA, BLK_IDLE, BLK_START, BLK_TERM, BLK_ERR} blk_kind_t;
    typedef enum logic {FR_IDLE, FR_FRAME} frame_t;

    // ---------------- TX encode ----------------
    logic [CTRL_WIDTH-1:0] tx_lane_idle;
    genvar gi;
    generate
        for (gi = 0; gi < CTRL_WIDTH; gi++) begin : g_tx_lane
            assign tx_lane_idle[gi] = (xgmii_txd[8*gi +: 8] == 8'h07);
        end
    endgenerate

    logic [63:0] enc_payload;
    logic [1:0]  enc_hdr;
    logic        enc_bad;

    always_comb begin
        enc_hdr     = SYNC_CTRL;
        enc_payload = {{8{7'h1E}}, 8'h1E};   // error block unless a valid pattern matches
        enc_bad     = 1'b1;
        if (xgmii_txc == 8'h00) begin
            enc_hdr     = SYNC_DATA;
            enc_payload = xgmii_txd;
            enc_bad     = 1'b0;
        end else if (xgmii_txc == 8'hFF && &tx_lane_idle) begin
            enc_payload = {56'd0, 8'h1E};
            enc_bad     = 1'b0;
        end else if (xgmii_txc == 8'h01 && xgmii_txd[7:0] == 8'hFB) begin
            enc_payload = {xgmii_txd[63:8], 8'h78};
            enc_bad     = 1'b0;
        end else if (xgmii_txc == 8'hFF && xgmii_txd[7:0] == 8'hFD && &tx_lane_idle[7:1]) begin
            enc_payload = {56'd0, 8'h87};
            enc_bad     = 1'b0;
        end
    end

    // Scrambler x^58+x^39+1, LSB first; the state shifts in scrambled bits.
    logic [57:0] scr_q, scr_d;
    logic [63:0] scr_out;
    always_comb begin
        scr_d   = scr_q;
        scr_out = '0;
        for (int i = 0; i < 64; i++) begin
            scr_out[i] = enc_payload[i] ^ scr_d[38] ^ scr_d[57];
            scr_d      = {scr_d[56:0], scr_out[i]};
        end
    end

    // PRBS31 generator: 66 bits per cycle, bits 0/1 form the header.
    logic [30:0] prbs_tx_q, prbs_tx_d;
    logic [65:0] prbs_tx_bits;
    always_comb begin
        prbs_tx_d    = prbs_tx_q;
        prbs_tx_bits = '0;
        for (int i = 0; i < 66; i++) begin
            prbs_tx_bits[i] = prbs_tx_d[30] ^ prbs_tx_d[27];
            prbs_tx_d       = {prbs_tx_d[29:0], prbs_tx_bits[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            serdes_tx_data <= '0;
            serdes_tx_hdr  <= '0;
            tx_bad_block   <= 1'b0;
            scr_q          <= '1;
            prbs_tx_q      <= '1;
        end else if (cfg_tx_prbs31_enable) begin
            serdes_tx_data <= prbs_tx_bits[65:2];
            serdes_tx_hdr  <= prbs_tx_bits[1:0];
            tx_bad_block   <= 1'b0;
            prbs_tx_q      <= prbs_tx_d;
        end else begin
            serdes_tx_data <= scr_out;
            serdes_tx_hdr  <= enc_hdr;
            tx_bad_block   <= enc_bad;
            scr_q          <= scr_d;
        end
    end

    // ---------------- RX descramble / PRBS check / decode ----------------
    logic hdr_valid;
    assign hdr_valid = (serdes_rx_hdr == SYNC_DATA) || (serdes_rx_hdr == SYNC_CTRL);

    // Descrambler shifts in the received (scrambled) bits, so it self-synchronises.
    logic [57:0] desc_q, desc_d;
    logic [63:0] desc_out;
    always_comb begin
        desc_d   = desc_q;
        desc_out = '0;
        for (int i = 0; i < 64; i++) begin
            desc_out[i] = serdes_rx_data[i] ^ desc_d[38] ^ desc_d[57];
            desc_d      = {desc_d[56:0], serdes_rx_data[i]};
        end
    end

    // Self-synchronous PRBS31 checker: each bit predicted from the prior 31 received.
    logic [65:0] rx_bits;
    logic [30:0] prbs_rx_q, prbs_rx_d;
    logic [6:0]  prbs_err;
    assign rx_bits = {serdes_rx_data, serdes_rx_hdr};
    always_comb begin
        prbs_rx_d = prbs_rx_q;
        prbs_err  = '0;
        for (int i = 0; i < 66; i++) begin
            prbs_err  = prbs_err + {6'd0, prbs_rx_d[30] ^ prbs_rx_d[27] ^ rx_bits[i]};
            prbs_rx_d = {prbs_rx_d[29:0], rx_bits[i]};
        end
    end

    logic [63:0] dec_rxd;
    logic [7:0]  dec_rxc;
    blk_kind_t   dec_kind;
    always_comb begin
        dec_rxd  = ERR_WORD;
        dec_rxc  = 8'hFF;
        dec_kind = BLK_ERR;
        if (serdes_rx_hdr == SYNC_DATA) begin
            dec_rxd  = desc_out;
            dec_rxc  = 8'h00;
            dec_kind = BLK_DATA;
        end else if (serdes_rx_hdr == SYNC_CTRL) begin
            case (desc_out[7:0])
                8'h1E: if (desc_out[63:8] == 56'd0) begin
                    dec_rxd  = IDLE_WORD;
                    dec_kind = BLK_IDLE;
                end
                8'h78: begin
                    dec_rxd  = {desc_out[63:8], 8'hFB};
                    dec_rxc  = 8'h01;
                    dec_kind = BLK_START;
                end
                8'h87: begin
                    dec_rxd  = {IDLE_WORD[63:8], 8'hFD};
                    dec_kind = BLK_TERM;
                end
                default: ;
            endcase
        end
    end

    // Frame FSM: state register, next state, output.
    frame_t frame_q, frame_d;
    logic   seq_err_d;
    logic   fsm_active;
    assign fsm_active = ~cfg_rx_prbs31_enable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_q <= FR_IDLE;
        else     frame_q <= frame_d;
    end

    always_comb begin
        frame_d = frame_q;
        if (fsm_active) begin
            case (dec_kind)
                BLK_START: frame_d = FR_FRAME;
                BLK_TERM,
                BLK_IDLE:  frame_d = FR_IDLE;
                default:   ;   // data keeps the state; error blocks are reported separately
            endcase
        end
    end

    always_comb begin
        seq_err_d = 1'b0;
        if (fsm_active) begin
            if (frame_q == FR_IDLE)
                seq_err_d = (dec_kind == BLK_DATA) || (dec_kind == BLK_TERM);
            else
                seq_err_d = (dec_kind == BLK_START) || (dec_kind == BLK_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xgmii_rxd         <= '0;
            xgmii_rxc         <= '0;
            rx_bad_block      <= 1'b0;
            rx_sequence_error <= 1'b0;
            rx_error_count    <= '0;
            desc_q            <= '1;
            prbs_rx_q         <= '1;
        end else begin
            desc_q <= desc_d;
            if (cfg_rx_prbs31_enable) begin
                xgmii_rxd         <= IDLE_WORD;
                xgmii_rxc         <= 8'hFF;
                rx_bad_block      <= 1'b0;
                rx_sequence_error <= 1'b0;
                rx_error_count    <= prbs_err;
                prbs_rx_q         <= prbs_rx_d;
            end else begin
                xgmii_rxd         <= dec_rxd;
                xgmii_rxc         <= dec_rxc;
                rx_bad_block      <= (dec_kind == BLK_ERR);
                rx_sequence_error <= seq_err_d;
                rx_error_count    <= '0;
            end
        end
    end

    // ---------------- Block lock, BER monitor, SerDes reset request ----------------
    logic [5:0]  lock_cnt_q, lock_cnt_d, win_cnt_q, win_cnt_d;
    logic [3:0]  inv_cnt_q, inv_cnt_d;
    logic [9:0]  ber_win_q, ber_win_d;
    logic [4:0]  ber_cnt_q, ber_cnt_d, ber_sum;
    logic [11:0] unlock_cnt_q, unlock_cnt_d;
    logic        lock_d, high_ber_d, bitslip_d, reset_req_d;

    always_comb begin
        lock_d     = rx_block_lock;
        lock_cnt_d = lock_cnt_q;
        win_cnt_d  = win_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        bitslip_d  = 1'b0;
        if (!rx_block_lock) begin
            win_cnt_d = '0;
            inv_cnt_d = '0;
            if (!hdr_valid) begin
                lock_cnt_d = '0;
                bitslip_d  = 1'b1;
            end else if (lock_cnt_q == 6'd63) begin
                lock_d     = 1'b1;
                lock_cnt_d = '0;
            end else begin
                lock_cnt_d = lock_cnt_q + 6'd1;
            end
        end else begin
            lock_cnt_d = '0;
            // The 16th bad header wins even when it lands on the last slot of a window.
            if (!hdr_valid && inv_cnt_q == 4'd15) begin
                lock_d    = 1'b0;
                bitslip_d = 1'b1;
                win_cnt_d = '0;
                inv_cnt_d = '0;
            end else if (win_cnt_q == 6'd63) begin
                win_cnt_d = '0;
                inv_cnt_d = '0;
            end else begin
                win_cnt_d = win_cnt_q + 6'd1;
                inv_cnt_d = inv_cnt_q + {3'd0, ~hdr_valid};
            end
        end
    end

    // BER count saturates at 16, which is all the threshold needs.
    always_comb begin
        ber_sum    = ber_cnt_q + {4'd0, ~hdr_valid & (ber_cnt_q != 5'd16)};
        high_ber_d = rx_high_ber | (ber_sum == 5'd16);
        ber_win_d  = ber_win_q + 10'd1;
        ber_cnt_d  = ber_sum;
        if (ber_win_q == 10'd1023) begin
            high_ber_d = (ber_sum == 5'd16);
            ber_cnt_d  = '0;
        end
    end

    always_comb begin
        reset_req_d  = 1'b0;
        unlock_cnt_d = unlock_cnt_q + 12'd1;
        if (rx_block_lock) begin
            unlock_cnt_d = '0;
        end else if (unlock_cnt_q == 12'd4095) begin
            reset_req_d  = 1'b1;
            unlock_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_block_lock       <= 1'b0;
            rx_high_ber         <= 1'b0;
            rx_status           <= 1'b0;
            serdes_rx_bitslip   <= 1'b0;
            serdes_rx_reset_req <= 1'b0;
            lock_cnt_q          <= '0;
            win_cnt_q           <= '0;
            inv_cnt_q           <= '0;
            ber_win_q           <= '0;
            ber_cnt_q           <= '0;
            unlock_cnt_q        <= '0;
        end else begin
            rx_block_lock       <= lock_d;
            rx_high_ber         <= high_ber_d;
            rx_status           <= lock_d & ~high_ber_d;
            serdes_rx_bitslip   <= bitslip_d;
            serdes_rx_reset_req <= reset_req_d;
            lock_cnt_q          <= lock_cnt_d;
            win_cnt_q           <= win_cnt_d;
            inv_cnt_q           <= inv_cnt_d;
            ber_win_q           <= ber_win_d;
            ber_cnt_q           <= ber_cnt_d;
            unlock_cnt_q        <= unlock_cnt_d;
        end
    end

endmodule

// File: tb/tb_eth_phy_10g.sv
// Directed testbench for eth_phy_10g: TX encoding against a scrambler reference,
// loopback lock/framing/error decoding, PRBS31 checking, and a dead-link run.
module tb_eth_phy_10g;
    localparam logic [63:0] IDLE_WORD = 64'h0707070707070707;

    logic        clk, rst;
    logic [63:0] xgmii_txd, xgmii_rxd, serdes_tx_data, serdes_rx_data;
    logic [7:0]  xgmii_txc, xgmii_rxc;
    logic [1:0]  serdes_tx_hdr, serdes_rx_hdr;
    logic        serdes_rx_bitslip, serdes_rx_reset_req;
    logic        tx_bad_block, rx_bad_block, rx_sequence_error;
    logic [6:0]  rx_error_count;
    logic        rx_block_lock, rx_high_ber, rx_status;
    logic        cfg_tx_prbs31_enable, cfg_rx_prbs31_enable;

    logic        lb;
    logic [63:0] flip, rx_drv_data;
    logic [1:0]  rx_drv_hdr;

    assign serdes_rx_data = lb ? (serdes_tx_data ^ flip) : rx_drv_data;
    assign serdes_rx_hdr  = lb ? serdes_tx_hdr : rx_drv_hdr;

    eth_phy_10g dut (
        .clk                  (clk),
        .rst                  (rst),
        .xgmii_txd            (xgmii_txd),
        .xgmii_txc            (xgmii_txc),
        .xgmii_rxd            (xgmii_rxd),
        .xgmii_rxc            (xgmii_rxc),
        .serdes_tx_data       (serdes_tx_data),
        .serdes_tx_hdr        (serdes_tx_hdr),
        .serdes_rx_data       (serdes_rx_data),
        .serdes_rx_hdr        (serdes_rx_hdr),
        .serdes_rx_bitslip    (serdes_rx_bitslip),
        .serdes_rx_reset_req  (serdes_rx_reset_req),
        .tx_bad_block         (tx_bad_block),
        .rx_bad_block         (rx_bad_block),
        .rx_sequence_error    (rx_sequence_error),
        .rx_error_count       (rx_error_count),
        .rx_block_lock        (rx_block_lock),
        .rx_high_ber          (rx_high_ber),
        .rx_status            (rx_status),
        .cfg_tx_prbs31_enable (cfg_tx_prbs31_enable),
        .cfg_rx_prbs31_enable (cfg_rx_prbs31_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference scrambler x^58+x^39+1, LSB first: returns {next_state, scrambled}.
    function automatic logic [121:0] scr_step(input logic [57:0] s, input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) begin
            o[i] = d[i] ^ s[38] ^ s[57];
            s    = {s[56:0], o[i]};
        end
        return {s, o};
    endfunction

    logic [7:0]   vc   [6];
    logic [63:0]  vd   [6];
    logic [1:0]   vh   [6];
    logic [63:0]  vp   [6];
    logic         vb   [6];
    logic [7:0]   fc   [5];
    logic [63:0]  fd   [5];
    logic [57:0]  tb_scr;
    logic [121:0] step_res;
    logic [63:0]  err_pl;
    int           found, slips;

    initial begin
        err_pl = {{8{7'h1E}}, 8'h1E};
        // TX encode vectors: txc, txd, expected header, unscrambled payload, bad flag
        vc[0] = 8'hFF; vd[0] = IDLE_WORD;            vh[0] = 2'b10; vp[0] = 64'h1E;               vb[0] = 1'b0;
        vc[1] = 8'h01; vd[1] = 64'hDDCCBBAA998877FB; vh[1] = 2'b10; vp[1] = 64'hDDCCBBAA99887778; vb[1] = 1'b0;
        vc[2] = 8'h00; vd[2] = 64'h0123456789ABCDEF; vh[2] = 2'b01; vp[2] = 64'h0123456789ABCDEF; vb[2] = 1'b0;
        vc[3] = 8'hFF; vd[3] = 64'h07070707070707FD; vh[3] = 2'b10; vp[3] = 64'h87;               vb[3] = 1'b0;
        vc[4] = 8'h0F; vd[4] = IDLE_WORD;            vh[4] = 2'b10; vp[4] = err_pl;               vb[4] = 1'b1;
        vc[5] = 8'hFF; vd[5] = 64'h07070707070707FB; vh[5] = 2'b10; vp[5] = err_pl;               vb[5] = 1'b1;
        // Frame: start, two data words, terminate, idle
        fc[0] = 8'h01; fd[0] = 64'h665544332211AAFB;
        fc[1] = 8'h00; fd[1] = 64'hFEEDFACECAFEBEEF;
        fc[2] = 8'h00; fd[2] = 64'h0011223344556677;
        fc[3] = 8'hFF; fd[3] = 64'h07070707070707FD;
        fc[4] = 8'hFF; fd[4] = IDLE_WORD;

        rst = 1'b0; lb = 1'b1; flip = '0; rx_drv_data = '0; rx_drv_hdr = 2'b00;
        xgmii_txd = IDLE_WORD; xgmii_txc = 8'hFF;
        cfg_tx_prbs31_enable = 1'b0; cfg_rx_prbs31_enable = 1'b0;
        #2 rst = 1'b1;
        tick(); tick();

        // Reset state
        check("rst_tx_data", serdes_tx_data, 64'h0);
        check("rst_tx_hdr", {62'd0, serdes_tx_hdr}, 64'h0);
        check("rst_rxd", xgmii_rxd, 64'h0);
        check("rst_rxc", {56'd0, xgmii_rxc}, 64'h0);
        check("rst_flags", {57'd0, serdes_rx_bitslip, serdes_rx_reset_req, tx_bad_block, rx_bad_block,
                            rx_sequence_error, rx_high_ber, rx_status}, 64'h0);
        check("rst_lock", {63'd0, rx_block_lock}, 64'h0);
        check("rst_errcnt", {57'd0, rx_error_count}, 64'h0);

        // TX encode + scramble against the reference
        rst = 1'b0;
        tb_scr = '1;
        for (int i = 0; i < 6; i++) begin
            xgmii_txd = vd[i]; xgmii_txc = vc[i];
            tick();
            step_res = scr_step(tb_scr, vp[i]);
            tb_scr   = step_res[121:64];
            check($sformatf("tx_hdr[%0d]", i), {62'd0, serdes_tx_hdr}, {62'd0, vh[i]});
            check($sformatf("tx_bad[%0d]", i), {63'd0, tx_bad_block}, {63'd0, vb[i]});
            check($sformatf("tx_data[%0d]", i), serdes_tx_data, step_res[63:0]);
        end

        // Asynchronous reset in the middle of traffic
        xgmii_txd = IDLE_WORD; xgmii_txc = 8'hFF;
        #2 rst = 1'b1;
        #1;
        check("async_rst_hdr", {62'd0, serdes_tx_hdr}, 64'h0);
        check("async_rst_data", serdes_tx_data, 64'h0);
        tick();
        rst = 1'b0;

        // First block after reset, then block lock in loopback
        tb_scr = '1;
        tick();
        step_res = scr_step(tb_scr, 64'h1E);
        check("post_rst_hdr", {62'd0, serdes_tx_hdr}, 64'h2);
        check("post_rst_data", serdes_tx_data, step_res[63:0]);
        check("first_bitslip", {63'd0, serdes_rx_bitslip}, 64'h1);
        tick();
        check("bitslip_clear", {63'd0, serdes_rx_bitslip}, 64'h0);
        repeat (62) tick();
        check("lock_at_64", {63'd0, rx_block_lock}, 64'h0);
        tick();
        check("lock_at_65", {63'd0, rx_block_lock}, 64'h1);
        check("status_at_65", {63'd0, rx_status}, 64'h1);
        repeat (5) tick();
        check("idle_rxd", xgmii_rxd, IDLE_WORD);
        check("idle_rxc", {56'd0, xgmii_rxc}, 64'hFF);
        check("idle_flags", {60'd0, rx_bad_block, rx_sequence_error, rx_high_ber, serdes_rx_bitslip}, 64'h0);

        // Framed traffic looped back: same XGMII words two cycles later
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                xgmii_txd = fd[i]; xgmii_txc = fc[i];
            end else begin
                xgmii_txd = IDLE_WORD; xgmii_txc = 8'hFF;
            end
            tick();
            if (i >= 1) begin
                check($sformatf("frame_rxd[%0d]", i - 1), xgmii_rxd, fd[i - 1]);
                check($sformatf("frame_rxc[%0d]", i - 1), {56'd0, xgmii_rxc}, {56'd0, fc[i - 1]});
                check($sformatf("frame_seq[%0d]", i - 1), {63'd0, rx_sequence_error}, 64'h0);
            end
        end

        // Data block while idle -> one-cycle sequence error
        xgmii_txd = 64'h1122334455667788; xgmii_txc = 8'h00;
        tick();
        xgmii_txd = IDLE_WORD; xgmii_txc = 8'hFF;
        tick();
        check("stray_data_rxd", xgmii_rxd, 64'h1122334455667788);
        check("stray_data_seq", {63'd0, rx_sequence_error}, 64'h1);
        tick();
        check("seq_err_pulse", {63'd0, rx_sequence_error}, 64'h0);

        // Unencodable control word -> error block on both sides
        xgmii_txd = IDLE_WORD; xgmii_txc = 8'h0F;
        tick();
        check("bad_tx_flag", {63'd0, tx_bad_block}, 64'h1);
        check("bad_tx_hdr", {62'd0, serdes_tx_hdr}, 64'h2);
        xgmii_txc = 8'hFF;
        tick();
        check("bad_tx_clear", {63'd0, tx_bad_block}, 64'h0);
        check("bad_rx_flag", {63'd0, rx_bad_block}, 64'h1);
        check("bad_rx_rxd", xgmii_rxd, 64'hFEFEFEFEFEFEFEFE);
        check("bad_rx_rxc", {56'd0, xgmii_rxc}, 64'hFF);
        tick();
        check("bad_rx_clear", {63'd0, rx_bad_block}, 64'h0);

        // PRBS31 loopback
        cfg_tx_prbs31_enable = 1'b1; cfg_rx_prbs31_enable = 1'b1;
        repeat (3) tick();
        check("prbs_err_0a", {57'd0, rx_error_count}, 64'h0);
        check("prbs_rxd", xgmii_rxd, IDLE_WORD);
        check("prbs_rxc", {56'd0, xgmii_rxc}, 64'hFF);
        tick();
        check("prbs_err_0b", {57'd0, rx_error_count}, 64'h0);
        flip = 64'h1;
        tick();
        flip = '0;
        check("prbs_err_flip", {57'd0, rx_error_count}, 64'h3);
        tick();
        check("prbs_err_after", {57'd0, rx_error_count}, 64'h0);
        cfg_tx_prbs31_enable = 1'b0; cfg_rx_prbs31_enable = 1'b0;

        // Dead link: header 00 forever
        lb = 1'b0; rx_drv_hdr = 2'b00; rx_drv_data = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        found = 0; slips = 0;
        for (int n = 1; n <= 5000 && found == 0; n++) begin
            tick();
            if (serdes_rx_bitslip) slips++;
            if (n == 15) check("ber_at_15", {63'd0, rx_high_ber}, 64'h0);
            if (n == 16) check("ber_at_16", {63'd0, rx_high_ber}, 64'h1);
            if (serdes_rx_reset_req) found = n;
        end
        check("reset_req_cycle", 64'(found), 64'd4096);
        check("bitslip_count", 64'(slips), 64'd4096);
        tick();
        check("reset_req_pulse", {63'd0, serdes_rx_reset_req}, 64'h0);
        check("dead_lock", {63'd0, rx_block_lock}, 64'h0);
        check("dead_status", {63'd0, rx_status}, 64'h0);
        check("dead_high_ber", {63'd0, rx_high_ber}, 64'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
